cla_serial_adder_ctrl: RTL
==========================

Name: cla_serial_adder_ctrl

Overview:
Sequencing controller that runs WIDTH-bit add/subtract operations through one shared carry_lookahead_4bit slice, one nibble per clock, LSB nibble first. The carry is chained between nibbles through a carry register. Operands are captured on a start/done handshake and the result is held until the next operation. This is the multi-word arithmetic front end for the 4-bit CLA datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (NIBBLES = WIDTH/4, derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse/level; sampled only when accept is allowed
op_sub  input  1  0 = a+b+c_in; 1 = a-b-c_in (c_in acts as borrow-in)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
c_in  input  1  carry-in (add) / borrow-in (sub), captured on accepted start
busy  output  1  high while nibbles are being processed
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result, held until next accepted start
c_out  output  1  raw carry out of MSB nibble (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow of the full-width result

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, done, c_out, ovf = 0; sum = 0.
  - Internal operand, carry and nibble-index registers = 0.
- States: IDLE, RUN, DONE.
- Accept rule: start is accepted at a rising edge only in IDLE or DONE. It is ignored in RUN; no queuing.
- On accept:
  - Latch a into a_r, and b into b_r. If op_sub = 1, latch ~b into b_r.
  - Set carry_r = c_in for add, ~c_in for sub.
  - Set idx = 0 and go to RUN.
  - sum is not cleared on accept.
- RUN, each cycle:
  - The slice sees a_r[4*idx+3:4*idx], b_r[4*idx+3:4*idx] and carry_r.
  - At the edge, the slice sum is written to sum[4*idx+3:4*idx], carry_r takes the slice carry-out, and idx increments.
  - Nibbles not yet processed keep their previous value.
- Last nibble (idx = NIBBLES-1), at that edge:
  - c_out = slice carry-out.
  - ovf = (a_r MSB == b_r MSB) && (new sum MSB != a_r MSB).
  - State goes to DONE.
- Latency: start sampled at edge T0 -> busy = 1 from T0 until T(NIBBLES) -> done = 1 for exactly the cycle between T(NIBBLES) and T(NIBBLES+1).
  - WIDTH = 16: done is high 4 cycles after the accepting edge.
- DONE:
  - done = 1, busy = 0.
  - If start = 1 at the next edge, go straight to RUN (back-to-back; done drops). Otherwise go to IDLE.
- busy = 1 only in RUN. done = 1 only in DONE. Both are registered and never high together.
- sum, c_out and ovf are stable from the done cycle until the first RUN-cycle edge of the next operation.
- Input changes on a, b, c_in and op_sub outside the accept edge have no effect.
- WIDTH = 4: a single RUN cycle, then DONE.
- Reset asserted mid-RUN: the operation is abandoned immediately and everything returns to reset values. done is never produced for the aborted operation.

Test Plan:
1. WIDTH=16, add a=16'h7777, b=16'h3333, c_in=0 -> sum=16'hAAAA, c_out=0, ovf=1. busy high 4 cycles; done is a single pulse 4 cycles after the accept edge.
2. Add a=16'hFFFF, b=16'h0001, c_in=0 -> sum=16'h0000, c_out=1, ovf=0. Add a=16'h7FFF, b=16'h0000, c_in=1 -> sum=16'h8000, c_out=0, ovf=1.
3. Sub a=16'h1000, b=16'h0001, c_in=0 -> sum=16'h0FFF, c_out=1, ovf=0. Sub a=16'h0000, b=16'h0001, c_in=0 -> sum=16'hFFFF, c_out=0 (borrow), ovf=0.
4. Hold start high continuously with operands changing every cycle:
   - Ops are accepted only at IDLE/DONE edges.
   - Operand changes during RUN do not affect the result.
   - The back-to-back op from DONE yields a second done 4 cycles after the first.
5. Pulse rst_n low asynchronously (between clock edges) during the 2nd RUN cycle of a=16'h1234 + b=16'h1111 -> all outputs are 0 immediately; no done pulse. A new start then gives sum=16'h2345.
6. Instance with WIDTH=4: a=4'b0111, b=4'b0011, c_in=0 -> sum=4'b1010, c_out=0, ovf=1, done 1 cycle after accept. A separate instance with WIDTH=8: a=8'hA5, b=8'h5A, c_in=1 -> sum=8'h00, c_out=1, ovf=0.

Source files
------------

// File: rtl/cla_serial_adder_ctrl_if.sv
// Operand/result bundle for the nibble-serial CLA adder controller.
// The requester drives start and the operands; the controller returns status and result.
interface cla_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, op_sub, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, op_sub, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/cla_serial_adder_ctrl.sv
// Runs WIDTH-bit add/subtract through one 4-bit carry-lookahead slice, LSB nibble first,
// chaining the carry between nibbles; result is held until the next operation starts.
module cla_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cla_serial_adder_ctrl_if.slave   bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       a_nib, b_nib;
    logic [4:0]       slice;

    // Single 4-bit carry-lookahead slice: returns {carry_out, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] g, p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
        slice = cla4(a_nib, b_nib, carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + ~borrow, so the slice only ever adds.
                    a_d     = bus.a;
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.c_in ^ bus.op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = slice[3:0];
                end
                carry_d = slice[4];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    c_out_d = slice[4];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice[3] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule
